// File: rtl/imuldiv_pkg.sv
// Shared constants for the integer multiply/divide sequencer: op encodings,
// FSM state encodings, iteration count and a magnitude helper.
package imuldiv_pkg;

  localparam int CPU_DATA_WIDTH  = 32;
  localparam int CPU_IMDOP_WIDTH = 4;
  localparam int IMD_STEPS       = 32;

  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_IDLE = 4'd0;
  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_MUL  = 4'd1;
  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_MULU = 4'd2;
  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_DIV  = 4'd3;
  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_DIVU = 4'd4;
  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_MFHI = 4'd5;
  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_MFLO = 4'd6;
  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_MTHI = 4'd7;
  localparam logic [CPU_IMDOP_WIDTH-1:0] CPU_IMDOP_MTLO = 4'd8;

  typedef enum logic [1:0] {
    IMD_ST_IDLE = 2'd0,
    IMD_ST_MUL  = 2'd1,
    IMD_ST_DIV  = 2'd2,
    IMD_ST_FIX  = 2'd3
  } imd_state_e;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, read as unsigned.
  function automatic logic [CPU_DATA_WIDTH-1:0] imd_abs(input logic [CPU_DATA_WIDTH-1:0] v,
                                                        input logic is_signed);
    imd_abs = (is_signed && v[CPU_DATA_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/imuldiv_ctl_step.sv
// One combinational iteration step: shift-add multiply (acc = {hi, multiplier})
// or restoring divide (acc = {remainder, dividend/quotient}).
module imuldiv_ctl_step
  import imuldiv_pkg::*;
(
  input  logic                        is_div,
  input  logic [2*CPU_DATA_WIDTH-1:0] acc,
  input  logic [CPU_DATA_WIDTH-1:0]   operand,
  output logic [2*CPU_DATA_WIDTH-1:0] acc_next
);

  logic [CPU_DATA_WIDTH:0] sum;
  logic [CPU_DATA_WIDTH:0] shifted;
  logic [CPU_DATA_WIDTH:0] diff;

  always_comb begin
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    acc_next = acc;
    if (!is_div) begin
      sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
      acc_next = {sum, acc[31:1]};
    end else begin
      // Remainder stays below the divisor, so bit 32 of diff is a clean borrow.
      shifted = {acc[63:32], acc[31]};
      diff    = shifted - {1'b0, operand};
      if (!diff[32]) acc_next = {diff[31:0], acc[30:0], 1'b1};
      else           acc_next = {shifted[31:0], acc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/imuldiv_ctl.sv
// Multiply/divide sequencer with HI/LO registers and pipeline stall generation.
// Define CPU_IMULDIV_FAST_MUL_EN for a single-cycle multiplier; DIV stays iterative.
module imuldiv_ctl
  import imuldiv_pkg::*;
(
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       i_pipe_stall,
  input  logic [CPU_IMDOP_WIDTH-1:0] i_imd_op,
  input  logic [CPU_DATA_WIDTH-1:0]  i_rs,
  input  logic [CPU_DATA_WIDTH-1:0]  i_rt,
  output logic [CPU_DATA_WIDTH-1:0]  o_result,
  output logic                       o_stall,
  output logic                       o_busy,
  output imd_state_e                 o_dbg_state
);

  // Handshake: decode holds i_imd_op while o_stall=1; the op is consumed on the
  // single edge where state==IDLE, op!=IDLE and i_pipe_stall=0.
  imd_state_e state, state_next;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_step, acc_neg;
  logic [31:0] opb, hi, lo, mag_rs, mag_rt;
  logic        is_div, is_signed, neg_res, neg_rem;
  logic        accept, op_mul, op_div, op_signed, iter_last;

  assign accept    = (state == IMD_ST_IDLE) && (i_imd_op != CPU_IMDOP_IDLE) && !i_pipe_stall;
  assign op_mul    = (i_imd_op == CPU_IMDOP_MUL) || (i_imd_op == CPU_IMDOP_MULU);
  assign op_div    = (i_imd_op == CPU_IMDOP_DIV) || (i_imd_op == CPU_IMDOP_DIVU);
  assign op_signed = (i_imd_op == CPU_IMDOP_MUL) || (i_imd_op == CPU_IMDOP_DIV);
  assign mag_rs    = imd_abs(i_rs, op_signed);
  assign mag_rt    = imd_abs(i_rt, op_signed);
  assign iter_last = (cnt == 5'(IMD_STEPS - 1));
  assign acc_neg   = ~acc + 64'd1;

`ifdef CPU_IMULDIV_FAST_MUL_EN
  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign prod_u = {32'd0, i_rs} * {32'd0, i_rt};
  localparam logic ITER_MUL = 1'b0;
`else
  localparam logic ITER_MUL = 1'b1;
`endif

  imuldiv_ctl_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (opb),
    .acc_next (acc_step)
  );

  always_comb begin
    state_next  = state;
    o_result    = '0;
    o_stall     = (state != IMD_ST_IDLE) && (i_imd_op != CPU_IMDOP_IDLE);
    o_busy      = (state != IMD_ST_IDLE);
    o_dbg_state = state;
    case (state)
      IMD_ST_IDLE: begin
        if (accept && op_mul && ITER_MUL)        state_next = IMD_ST_MUL;
        else if (accept && op_div && i_rt != '0) state_next = IMD_ST_DIV;
        if (i_imd_op == CPU_IMDOP_MFHI) o_result = hi;
        if (i_imd_op == CPU_IMDOP_MFLO) o_result = lo;
      end
      IMD_ST_MUL, IMD_ST_DIV:
        if (iter_last) state_next = is_signed ? IMD_ST_FIX : IMD_ST_IDLE;
      default: state_next = IMD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IMD_ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      opb       <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
    end else begin
      case (state)
        IMD_ST_IDLE: if (accept) begin
          if (i_imd_op == CPU_IMDOP_MTHI) hi <= i_rs;
          if (i_imd_op == CPU_IMDOP_MTLO) lo <= i_rs;
`ifdef CPU_IMULDIV_FAST_MUL_EN
          if (i_imd_op == CPU_IMDOP_MUL)  {hi, lo} <= prod_s;
          if (i_imd_op == CPU_IMDOP_MULU) {hi, lo} <= prod_u;
`endif
          if (op_div && i_rt == '0) begin
            hi <= i_rs;
            lo <= 32'hFFFF_FFFF;
          end else if (op_div || (op_mul && ITER_MUL)) begin
            // Divide iterates on the dividend, multiply on the multiplier.
            is_div    <= op_div;
            is_signed <= op_signed;
            neg_res   <= op_signed && (i_rs[31] ^ i_rt[31]);
            neg_rem   <= op_signed && i_rs[31];
            cnt       <= '0;
            acc       <= {32'd0, op_div ? mag_rs : mag_rt};
            opb       <= op_div ? mag_rt : mag_rs;
          end
        end
        IMD_ST_MUL, IMD_ST_DIV: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
          if (iter_last && !is_signed) {hi, lo} <= acc_step;
        end
        default: begin
          if (!is_div) begin
            {hi, lo} <= neg_res ? acc_neg : acc;
          end else begin
            lo <= neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
            hi <= neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_ctl.sv
// Directed bench for imuldiv_ctl: mul/div vectors, hazard stalls, MTxx with
// pipe stall, and reset abort. Expectations are hand-computed constants.
module tb_imuldiv_ctl;
  import imuldiv_pkg::*;

`ifdef CPU_IMULDIV_FAST_MUL_EN
  localparam int MUL_U_LAT = 0;
  localparam int MUL_S_LAT = 0;
`else
  localparam int MUL_U_LAT = 32;
  localparam int MUL_S_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_pipe_stall;
  logic [3:0]  i_imd_op;
  logic [31:0] i_rs, i_rt;
  logic [31:0] o_result;
  logic        o_stall, o_busy;
  imd_state_e  o_dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, hi, lo;
    int          lat;
  } vec_t;
  vec_t vecs[10];

  imuldiv_ctl dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_pipe_stall (i_pipe_stall),
    .i_imd_op     (i_imd_op),
    .i_rs         (i_rs),
    .i_rt         (i_rt),
    .o_result     (o_result),
    .o_stall      (o_stall),
    .o_busy       (o_busy),
    .o_dbg_state  (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    i_imd_op = op;
    i_rs     = rs;
    i_rt     = rt;
    #1;
    check("issue_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    i_imd_op = CPU_IMDOP_IDLE;
    #1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (o_busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic read_hilo(input string tag);
    @(negedge clk);
    i_imd_op = CPU_IMDOP_MFHI;
    #1;
    check({tag, "_hi"}, o_result, exp_q.pop_front());
    i_imd_op = CPU_IMDOP_MFLO;
    #1;
    check({tag, "_lo"}, o_result, exp_q.pop_front());
    i_imd_op = CPU_IMDOP_IDLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0] = '{CPU_IMDOP_MULU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, MUL_U_LAT};
    vecs[1] = '{CPU_IMDOP_MUL,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_S_LAT};
    vecs[2] = '{CPU_IMDOP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3] = '{CPU_IMDOP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        32};
    vecs[4] = '{CPU_IMDOP_DIVU, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0};
    vecs[5] = '{CPU_IMDOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vecs[6] = '{CPU_IMDOP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    vecs[7] = '{CPU_IMDOP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         MUL_S_LAT};
    vecs[8] = '{CPU_IMDOP_DIV,  32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 0};
    vecs[9] = '{CPU_IMDOP_MULU, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780, MUL_U_LAT};

    // Clock/reset
    nrst         = 1'b0;
    i_pipe_stall = 1'b0;
    i_imd_op     = CPU_IMDOP_IDLE;
    i_rs         = '0;
    i_rt         = '0;
    #12;
    check("rst_busy",  32'(o_busy),      32'd0);
    check("rst_stall", 32'(o_stall),     32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    check("rst_res",   o_result,         32'd0);
    i_imd_op = CPU_IMDOP_MFHI;
    #1;
    check("rst_hi", o_result, 32'd0);
    i_imd_op = CPU_IMDOP_MFLO;
    #1;
    check("rst_lo", o_result, 32'd0);
    i_imd_op = CPU_IMDOP_IDLE;
    @(negedge clk);
    nrst = 1'b1;

    // Multiply/divide vectors with busy-cycle count
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_idle(cyc);
      check($sformatf("v%0d_lat", i), 32'(cyc), 32'(vecs[i].lat));
      exp_q.push_back(vecs[i].hi);
      exp_q.push_back(vecs[i].lo);
      read_hilo($sformatf("v%0d", i));
    end

    // Hazard window: non-IMD op never stalls, MFLO waits until idle
    issue(CPU_IMDOP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    #1;
    check("nonimd_stall", 32'(o_stall), 32'd0);
    check("nonimd_busy",  32'(o_busy),  32'd1);
    repeat (3) @(negedge clk);
    i_imd_op = CPU_IMDOP_MFLO;
    #1;
    cyc = 0;
    while (o_busy === 1'b1 && cyc < 100) begin
      check("mf_stall_busy", 32'(o_stall), 32'd1);
      cyc++;
      @(negedge clk);
      #1;
    end
    check("mf_wait_cycles", 32'(cyc), 32'd28);
    check("mf_stall_idle", 32'(o_stall), 32'd0);
    check("mf_result", o_result, 32'd14);
    i_imd_op = CPU_IMDOP_IDLE;

    // MTHI held off by pipe stall, then MTLO
    @(negedge clk);
    i_pipe_stall = 1'b1;
    i_imd_op     = CPU_IMDOP_MTHI;
    i_rs         = 32'h1234;
    repeat (3) @(negedge clk);
    i_imd_op = CPU_IMDOP_MFHI;
    #1;
    check("mthi_held", o_result, 32'd2);
    i_imd_op     = CPU_IMDOP_MTHI;
    i_pipe_stall = 1'b0;
    @(negedge clk);
    i_imd_op = CPU_IMDOP_MFHI;
    #1;
    check("mthi", o_result, 32'h1234);
    issue(CPU_IMDOP_MTLO, 32'h55, 32'd0);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h55);
    read_hilo("mt");

    // Reset pulse mid-multiply
    issue(CPU_IMDOP_MUL, 32'hFFFF_FFFD, 32'd7);
    repeat (4) @(negedge clk);
    #1;
    check("pre_rst_busy", 32'(o_busy), (MUL_S_LAT > 6) ? 32'd1 : 32'd0);
    nrst = 1'b0;
    #1;
    check("mid_rst_busy",  32'(o_busy),      32'd0);
    check("mid_rst_state", 32'(o_dbg_state), 32'd0);
    #1;
    nrst = 1'b1;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    read_hilo("post_rst");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
